// File: rtl/reg_arbiter.sv
// Two-requester (core, debug) register-file access arbiter.
// Core has priority; debug is forced through after STARVE_MAX contested core grants.
module reg_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_dr,
  input  logic [2:0]  core_sr1,
  input  logic [2:0]  core_sr2,
  input  logic [15:0] core_wdata,
  output logic        core_ack,
  output logic [15:0] core_rdata1,
  output logic [15:0] core_rdata2,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic        rf_ld,
  output logic [2:0]  rf_dr,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_sr1_in,
  input  logic [15:0] rf_sr2_in
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       own_dbg;
  logic       dbg_wins;

  assign dbg_wins = dbg_req && (!core_req || starve_cnt == SMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      own_dbg     <= 1'b0;
      rf_ld       <= 1'b0;
      rf_dr       <= 3'd0;
      rf_sr1      <= 3'd0;
      rf_sr2      <= 3'd0;
      rf_wdata    <= 16'd0;
      core_ack    <= 1'b0;
      dbg_ack     <= 1'b0;
      core_rdata1 <= 16'd0;
      core_rdata2 <= 16'd0;
      dbg_rdata   <= 16'd0;
    end else begin
      // Register-file drives and acks are single-cycle; clear unless set below.
      rf_ld    <= 1'b0;
      rf_dr    <= 3'd0;
      rf_sr1   <= 3'd0;
      rf_sr2   <= 3'd0;
      rf_wdata <= 16'd0;
      core_ack <= 1'b0;
      dbg_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req || dbg_req) begin
            own_dbg <= dbg_wins;
            if (dbg_wins) begin
              starve_cnt <= 4'd0;
              if (dbg_we) begin
                state    <= WR;
                rf_ld    <= 1'b1;
                rf_dr    <= dbg_addr;
                rf_wdata <= dbg_wdata;
              end else begin
                state  <= RD;
                rf_sr1 <= dbg_addr;
              end
            end else begin
              if (dbg_req && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 4'd1;
              if (core_we) begin
                state    <= WR;
                rf_ld    <= 1'b1;
                rf_dr    <= core_dr;
                rf_wdata <= core_wdata;
              end else begin
                state  <= RD;
                rf_sr1 <= core_sr1;
                rf_sr2 <= core_sr2;
              end
            end
          end
        end
        WR: begin
          state    <= ACK;
          core_ack <= !own_dbg;
          dbg_ack  <= own_dbg;
        end
        // Register file registers its read ports, so data lands one cycle after RD.
        RD: state <= CAP;
        CAP: begin
          state    <= ACK;
          core_ack <= !own_dbg;
          dbg_ack  <= own_dbg;
          if (own_dbg) begin
            dbg_rdata <= rf_sr1_in;
          end else begin
            core_rdata1 <= rf_sr1_in;
            core_rdata2 <= rf_sr2_in;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a registered register-file model and an
// ack scoreboard.
module tb_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [2:0]  core_dr, core_sr1, core_sr2;
  logic [15:0] core_wdata;
  logic        core_ack;
  logic [15:0] core_rdata1, core_rdata2;
  logic        dbg_req, dbg_we;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic        rf_ld;
  logic [2:0]  rf_dr, rf_sr1, rf_sr2;
  logic [15:0] rf_wdata;
  logic [15:0] rf_sr1_in, rf_sr2_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dbg;
    logic        rd;
    logic [15:0] d1;
    logic [15:0] d2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  reg_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_dr(core_dr),
    .core_sr1(core_sr1), .core_sr2(core_sr2), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata1(core_rdata1), .core_rdata2(core_rdata2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_ld(rf_ld), .rf_dr(rf_dr), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
    .rf_wdata(rf_wdata), .rf_sr1_in(rf_sr1_in), .rf_sr2_in(rf_sr2_in)
  );

  // Register file with registered read ports, preset on reset.
  logic [15:0] regs [8];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'(i) * 16'h1111;
      regs[2]   <= 16'h1234;
      regs[7]   <= 16'h0042;
      rf_sr1_in <= 16'h0;
      rf_sr2_in <= 16'h0;
    end else begin
      if (rf_ld) regs[rf_dr] <= rf_wdata;
      rf_sr1_in <= regs[rf_sr1];
      rf_sr2_in <= regs[rf_sr2];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ack pops the oldest expected transaction.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (core_ack || dbg_ack) begin
        chk("ack_excl", {15'd0, core_ack & dbg_ack}, 16'd0);
        chk("ack_expected", {15'd0, sb.size() > 0}, 16'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_src", {15'd0, dbg_ack}, {15'd0, e.dbg});
          if (e.rd && e.dbg) chk("sb_dbg_rdata", dbg_rdata, e.d1);
          if (e.rd && !e.dbg) begin
            chk("sb_rdata1", core_rdata1, e.d1);
            chk("sb_rdata2", core_rdata2, e.d2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    core_req = 0; core_we = 0; core_dr = 0; core_sr1 = 0; core_sr2 = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_rf_ld",    {15'd0, rf_ld}, 16'd0);
    chk("rst_core_ack", {15'd0, core_ack}, 16'd0);
    chk("rst_dbg_ack",  {15'd0, dbg_ack}, 16'd0);
    chk("rst_rf_dr",    {13'd0, rf_dr}, 16'd0);
    chk("rst_rf_sr1",   {13'd0, rf_sr1}, 16'd0);
    chk("rst_rdata1",   core_rdata1, 16'd0);
    chk("rst_dbg_rdata", dbg_rdata, 16'd0);
    chk("rst_state",    16'(dut.state), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Core write R5 = BEEF
    core_req = 1; core_we = 1; core_dr = 3'd5; core_wdata = 16'hBEEF;
    sb.push_back('{1'b0, 1'b0, 16'h0, 16'h0});
    tick();
    chk("wr_rf_ld", {15'd0, rf_ld}, 16'd1);
    chk("wr_rf_dr", {13'd0, rf_dr}, 16'd5);
    chk("wr_rf_wdata", rf_wdata, 16'hBEEF);
    chk("wr_ack_early", {15'd0, core_ack}, 16'd0);
    core_req = 0; core_we = 0;
    tick();
    chk("wr_ack", {15'd0, core_ack}, 16'd1);
    chk("wr_rf_ld_off", {15'd0, rf_ld}, 16'd0);
    chk("wr_rf_dr_off", {13'd0, rf_dr}, 16'd0);
    tick();
    chk("wr_ack_pulse", {15'd0, core_ack}, 16'd0);
    chk("wr_idle", 16'(dut.state), 16'd0);

    // Core read R5, R2
    core_req = 1; core_sr1 = 3'd5; core_sr2 = 3'd2;
    sb.push_back('{1'b0, 1'b1, 16'hBEEF, 16'h1234});
    tick();
    chk("rd_sr1", {13'd0, rf_sr1}, 16'd5);
    chk("rd_sr2", {13'd0, rf_sr2}, 16'd2);
    chk("rd_rf_ld", {15'd0, rf_ld}, 16'd0);
    core_req = 0;
    tick();
    chk("rd_ack_early", {15'd0, core_ack}, 16'd0);
    chk("rd_sr1_off", {13'd0, rf_sr1}, 16'd0);
    tick();
    chk("rd_ack", {15'd0, core_ack}, 16'd1);
    chk("rd_rdata1", core_rdata1, 16'hBEEF);
    chk("rd_rdata2", core_rdata2, 16'h1234);
    tick();

    // Debug read R7
    dbg_req = 1; dbg_we = 0; dbg_addr = 3'd7;
    sb.push_back('{1'b1, 1'b1, 16'h0042, 16'h0});
    tick();
    chk("drd_sr1", {13'd0, rf_sr1}, 16'd7);
    chk("drd_rf_ld1", {15'd0, rf_ld}, 16'd0);
    dbg_req = 0;
    tick();
    chk("drd_rf_ld2", {15'd0, rf_ld}, 16'd0);
    chk("drd_ack_early", {15'd0, dbg_ack}, 16'd0);
    tick();
    chk("drd_ack", {15'd0, dbg_ack}, 16'd1);
    chk("drd_rdata", dbg_rdata, 16'h0042);
    chk("drd_rf_ld3", {15'd0, rf_ld}, 16'd0);
    chk("drd_core_hold", core_rdata1, 16'hBEEF);
    tick();

    // Starvation: both held high
    core_req = 1; core_we = 0; core_sr1 = 3'd5; core_sr2 = 3'd2;
    dbg_req = 1; dbg_addr = 3'd7;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 1'b1, 16'hBEEF, 16'h1234});
    sb.push_back('{1'b1, 1'b1, 16'h0042, 16'h0});
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      tick();
      if (core_ack || dbg_ack) begin
        n++;
        if (n == 4) chk("starve_sat", 16'(dut.starve_cnt), 16'd4);
        if (n == 5) begin core_req = 0; dbg_req = 0; end
      end
    end
    core_req = 0; dbg_req = 0;
    chk("starve_acks", 16'(n), 16'd5);
    tick();
    chk("starve_clear", 16'(dut.starve_cnt), 16'd0);
    chk("starve_idle", 16'(dut.state), 16'd0);

    // Simultaneous first request
    core_req = 1; dbg_req = 1;
    sb.push_back('{1'b0, 1'b1, 16'hBEEF, 16'h1234});
    tick();
    chk("sim_starve", 16'(dut.starve_cnt), 16'd1);
    chk("sim_core_sel", {13'd0, rf_sr1}, 16'd5);
    core_req = 0; dbg_req = 0;
    tick();
    tick();
    chk("sim_core_ack", {15'd0, core_ack}, 16'd1);
    chk("sim_dbg_ack", {15'd0, dbg_ack}, 16'd0);
    tick();

    // Reset in the middle of a write
    core_req = 1; core_we = 1; core_dr = 3'd3; core_wdata = 16'hAAAA;
    sb.push_back('{1'b0, 1'b0, 16'h0, 16'h0});
    tick();
    chk("rstw_rf_ld", {15'd0, rf_ld}, 16'd1);
    core_req = 0; core_we = 0;
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk("rstw_rf_ld_async", {15'd0, rf_ld}, 16'd0);
    chk("rstw_rf_dr", {13'd0, rf_dr}, 16'd0);
    chk("rstw_state", 16'(dut.state), 16'd0);
    chk("rstw_starve", 16'(dut.starve_cnt), 16'd0);
    tick();
    chk("rstw_no_ack", {15'd0, core_ack}, 16'd0);
    rst = 1'b1;
    tick();
    chk("rstw_idle", 16'(dut.state), 16'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rstw_quiet_ack", {15'd0, core_ack | dbg_ack}, 16'd0);
      chk("rstw_quiet_ld", {15'd0, rf_ld}, 16'd0);
      tick();
    end
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive contested core grants before debug is forced a grant; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 core_req  input  1  core requests a register-file access.
REQ-005 core_we  input  1  1 = write, 0 = read.
REQ-006 core_dr  input  3  write destination register.
REQ-007 core_sr1, core_sr2  input  3 each  read source registers.
REQ-008 core_wdata  input  16  write data.
REQ-009 core_ack  output  1  one-cycle completion pulse.
REQ-010 core_rdata1, core_rdata2  output  16 each  read results, valid with core_ack.
REQ-011 dbg_req, dbg_we  input  1 each  debug request and write enable.
REQ-012 dbg_addr  input  3  debug register index, used for both reads and writes.
REQ-013 dbg_wdata  input  16  debug write data.
REQ-014 dbg_ack  output  1  one-cycle completion pulse.
REQ-015 dbg_rdata  output  16  debug read result, valid with dbg_ack.
REQ-016 rf_ld  output  1  register-file load enable.
REQ-017 rf_dr, rf_sr1, rf_sr2  output  3 each  register-file selects.
REQ-018 rf_wdata  output  16  register-file write data.
REQ-019 rf_sr1_in, rf_sr2_in  input  16 each  registered register-file read outputs.

Function
REQ-020 The FSM SHALL have states IDLE, WR, RD, CAP and ACK; all outputs SHALL be registered.
REQ-021 In IDLE with any request present, the block SHALL grant one requester and latch that requester's op, selects and wdata.
- Next state is WR for a write, RD for a read.
- The block SHALL ignore requester inputs after the grant until the next IDLE.
REQ-022 Arbitration SHALL work as follows.
- Core wins a contest unless starve_cnt == STARVE_MAX, in which case debug wins.
- A sole requester always wins.
REQ-023 starve_cnt (4-bit) SHALL behave as follows.
- Increments when core is granted while dbg_req = 1.
- Clears when debug is granted.
- Saturates at STARVE_MAX.
REQ-024 WR SHALL last exactly one cycle.
- Drives rf_ld = 1, rf_dr = latched dr, rf_wdata = latched wdata.
- Then goes to ACK.
REQ-025 RD SHALL last exactly one cycle.
- Drives rf_ld = 0 and rf_sr1/rf_sr2 = latched selects; a debug read drives dbg_addr on rf_sr1.
- Then goes to CAP.
REQ-026 CAP SHALL capture read data, then go to ACK.
- Core read: rf_sr1_in into core_rdata1 and rf_sr2_in into core_rdata2.
- Debug read: rf_sr1_in into dbg_rdata.
REQ-027 ACK SHALL pulse the granted requester's ack for exactly one cycle, then return to IDLE.
REQ-028 Latency SHALL be measured from the IDLE grant cycle T.
- Write: rf_ld high in T+1, ack in T+2.
- Read: selects in T+1, capture in T+2, ack in T+3.
REQ-029 rf_ld SHALL be 1 only in WR and never in RD/CAP, so register-file reads are never blocked.
REQ-030 Outside WR/RD, rf_dr/rf_sr1/rf_sr2/rf_wdata SHALL hold 0.
REQ-031 rdata outputs SHALL hold their value until the next capture for the same requester.
REQ-032 A requester holding req high through ack SHALL be treated as a new request in the following IDLE cycle, arbitrated normally.
REQ-033 Deasserting req after the grant SHALL NOT abort the transaction; the ack still issues.
REQ-034 core_ack and dbg_ack SHALL never be high in the same cycle.

Reset
REQ-035 rst = 0 SHALL immediately, without waiting for a clock edge, set the following.
- State IDLE, starve_cnt 0.
- rf_ld, core_ack, dbg_ack = 0.
- All selects, rf_wdata and rdata outputs = 0.
REQ-036 Reset mid-transaction SHALL abandon the access with no ack and no further rf_ld.
REQ-037 The first grant SHALL occur no earlier than the first rising edge after rst returns to 1.

Verification
REQ-038 The bench SHALL cover a core write: core_we = 1, dr = 5, wdata = 16'hBEEF at T -> rf_ld = 1, rf_dr = 5 at T+1; core_ack at T+2.
REQ-039 The bench SHALL cover a core read: sr1 = 5, sr2 = 2, with the model holding R5 = BEEF, R2 = 1234 -> core_ack at T+3 with rdata1 = BEEF, rdata2 = 1234.
REQ-040 The bench SHALL cover starvation: core_req and dbg_req held high, STARVE_MAX = 4 -> four core grants, then one debug grant, then the counter clears.
REQ-041 The bench SHALL cover a debug read: dbg_addr = 7, R7 = 0042 -> dbg_rdata = 0042 with dbg_ack at T+3; rf_ld stays 0 throughout.
REQ-042 The bench SHALL cover reset mid-write: rst low during WR -> rf_ld drops asynchronously, no ack, state IDLE after release.
REQ-043 The bench SHALL cover a simultaneous first request: both requesters assert in the same IDLE cycle with starve_cnt = 0 -> core granted, starve_cnt = 1.
